// File: rtl/alu_muldiv_if.sv
// Request/response bundle for the alu_muldiv block: operands and opcode in,
// registered result words and status flags out.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             overflow;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, result_hi, zero, overflow, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, result_hi, zero, overflow, div_by_zero
  );
endinterface

// File: rtl/alu_muldiv.sv
// Single-cycle ALU with iterative unsigned shift-add multiply and restoring
// divide; one WIDTH-iteration engine shared by MULU and DIVU.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  alu_muldiv_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_EQ   = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t           state_r, state_nx_s;
  logic [SHW-1:0]   cnt_r;
  logic [WIDTH-1:0] opa_r, hi_r, lo_r;
  logic [WIDTH-1:0] result_r, result_hi_r;
  logic             busy_r, done_r, zero_r, overflow_r, div_by_zero_r;

  logic             accept_s, last_s, is_mul_s, is_div_s;
  logic [SHW-1:0]   sh_s;
  logic [WIDTH-1:0] sum_s, diff_s, negb_s;
  logic [WIDTH-1:0] alu_res_s, alu_hi_s;
  logic             alu_valid_s, alu_ovf_s, alu_dbz_s;
  logic [WIDTH:0]   mul_sum_s, div_sh_s, div_diff_s;
  logic [WIDTH-1:0] mul_hi_s, mul_lo_s, div_hi_s, div_lo_s;
  logic             out_load_s, out_done_s, out_zero_s, out_ovf_s, out_dbz_s;
  logic [WIDTH-1:0] out_res_s, out_hi_s;

  assign accept_s = bus.start && (state_r == ST_IDLE);
  assign is_mul_s = (bus.op == OP_MULU);
  assign is_div_s = (bus.op == OP_DIVU) && (bus.b != {WIDTH{1'b0}});
  assign last_s   = (cnt_r == SHW'(WIDTH - 1));
  assign sh_s     = bus.b[SHW-1:0];
  assign sum_s    = bus.a + bus.b;
  assign diff_s   = bus.a - bus.b;
  assign negb_s   = ~bus.b + {{(WIDTH-1){1'b0}}, 1'b1};

  // Single-cycle operation results, computed straight from the live operands.
  always_comb begin
    alu_res_s   = {WIDTH{1'b0}};
    alu_hi_s    = {WIDTH{1'b0}};
    alu_valid_s = 1'b1;
    alu_ovf_s   = 1'b0;
    alu_dbz_s   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res_s = sum_s;
        alu_ovf_s = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = diff_s;
        alu_ovf_s = (bus.a[WIDTH-1] == negb_s[WIDTH-1]) && (diff_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  alu_res_s = bus.a & bus.b;
      OP_OR:   alu_res_s = bus.a | bus.b;
      OP_XOR:  alu_res_s = bus.a ^ bus.b;
      OP_NOR:  alu_res_s = ~(bus.a | bus.b);
      OP_EQ:   alu_res_s = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLL:  alu_res_s = bus.a << sh_s;
      OP_SRL:  alu_res_s = bus.a >> sh_s;
      OP_SRA:  alu_res_s = $unsigned($signed(bus.a) >>> sh_s);
      OP_MULU: alu_res_s = {WIDTH{1'b0}};
      OP_DIVU: begin
        // Only reaches the outputs when b==0; b!=0 goes to the iterative path.
        alu_res_s = {WIDTH{1'b1}};
        alu_hi_s  = bus.a;
        alu_dbz_s = 1'b1;
      end
      default: alu_valid_s = 1'b0;
    endcase
  end

  // One iteration of shift-add multiply (hi:lo = partial product : multiplier)
  // and restoring divide (hi:lo = remainder : dividend/quotient).
  always_comb begin
    mul_sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opa_r} : {(WIDTH+1){1'b0}});
    mul_hi_s   = mul_sum_s[WIDTH:1];
    mul_lo_s   = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    div_sh_s   = {hi_r, lo_r[WIDTH-1]};
    div_diff_s = div_sh_s - {1'b0, opa_r};
    if (!div_diff_s[WIDTH]) begin
      div_hi_s = div_diff_s[WIDTH-1:0];
      div_lo_s = {lo_r[WIDTH-2:0], 1'b1};
    end else begin
      div_hi_s = div_sh_s[WIDTH-1:0];
      div_lo_s = {lo_r[WIDTH-2:0], 1'b0};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && is_mul_s) begin
          state_nx_s = ST_MUL;
        end else if (accept_s && is_div_s) begin
          state_nx_s = ST_DIV;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (last_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = state_r;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Output update selection: what gets written to the result registers and when.
  always_comb begin
    out_load_s = 1'b0;
    out_done_s = 1'b0;
    out_res_s  = alu_res_s;
    out_hi_s   = alu_hi_s;
    out_zero_s = alu_valid_s && (alu_res_s == {WIDTH{1'b0}});
    out_ovf_s  = alu_ovf_s;
    out_dbz_s  = alu_dbz_s;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !is_mul_s && !is_div_s) begin
          out_load_s = 1'b1;
          out_done_s = 1'b1;
        end else begin
          out_load_s = 1'b0;
        end
      end
      ST_MUL: begin
        out_res_s  = mul_lo_s;
        out_hi_s   = mul_hi_s;
        out_zero_s = (mul_lo_s == {WIDTH{1'b0}});
        out_ovf_s  = 1'b0;
        out_dbz_s  = 1'b0;
        out_load_s = last_s;
        out_done_s = last_s;
      end
      ST_DIV: begin
        out_res_s  = div_lo_s;
        out_hi_s   = div_hi_s;
        out_zero_s = (div_lo_s == {WIDTH{1'b0}});
        out_ovf_s  = 1'b0;
        out_dbz_s  = 1'b0;
        out_load_s = last_s;
        out_done_s = last_s;
      end
      default: out_load_s = 1'b0;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r         <= {SHW{1'b0}};
      opa_r         <= {WIDTH{1'b0}};
      hi_r          <= {WIDTH{1'b0}};
      lo_r          <= {WIDTH{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      result_r      <= {WIDTH{1'b0}};
      result_hi_r   <= {WIDTH{1'b0}};
      zero_r        <= 1'b0;
      overflow_r    <= 1'b0;
      div_by_zero_r <= 1'b0;
    end else begin
      busy_r <= (state_nx_s != ST_IDLE);
      done_r <= out_done_s;
      if (state_r == ST_IDLE) begin
        cnt_r <= {SHW{1'b0}};
        hi_r  <= {WIDTH{1'b0}};
        opa_r <= is_mul_s ? bus.a : bus.b;
        lo_r  <= is_mul_s ? bus.b : bus.a;
      end else begin
        cnt_r <= cnt_r + {{(SHW-1){1'b0}}, 1'b1};
        hi_r  <= (state_r == ST_MUL) ? mul_hi_s : div_hi_s;
        lo_r  <= (state_r == ST_MUL) ? mul_lo_s : div_lo_s;
      end
      if (out_load_s) begin
        result_r      <= out_res_s;
        result_hi_r   <= out_hi_s;
        zero_r        <= out_zero_s;
        overflow_r    <= out_ovf_s;
        div_by_zero_r <= out_dbz_s;
      end else begin
        result_r      <= result_r;
        result_hi_r   <= result_hi_r;
        zero_r        <= zero_r;
        overflow_r    <= overflow_r;
        div_by_zero_r <= div_by_zero_r;
      end
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.result      = result_r;
  assign bus.result_hi   = result_hi_r;
  assign bus.zero        = zero_r;
  assign bus.overflow    = overflow_r;
  assign bus.div_by_zero = div_by_zero_r;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed, table-driven bench for alu_muldiv at WIDTH=32, with hand-written
// sequences for the iterative, busy-ignore, back-to-back and reset cases.
module tb_alu_muldiv;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_muldiv_if #(.WIDTH(W)) bus ();
  alu_muldiv #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         ovf;
    logic         dbz;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [W-1:0] res, input logic [W-1:0] hi,
                            input logic z, input logic ovf, input logic dbz);
    check({name, ".result"}, 64'(bus.result), 64'(res));
    check({name, ".result_hi"}, 64'(bus.result_hi), 64'(hi));
    check({name, ".flags"}, 64'({bus.zero, bus.overflow, bus.div_by_zero}), 64'({z, ovf, dbz}));
  endtask

  // Drives one start pulse; returns #1 after the sampling edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Iterative op: checks latency, busy span, results, and optionally a start during busy.
  task automatic run_multi(input string name, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] res,
                           input logic [W-1:0] hi, input logic z, input logic inject);
    int n = 1;
    int busy_cnt = 0;
    issue(op, a, b);
    while (!bus.done && n < 100) begin
      if (bus.busy) busy_cnt++;
      if (inject && n == 5) begin
        bus.start = 1'b1; bus.op = 4'b0000; bus.a = 32'd1; bus.b = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    check({name, ".latency"}, 64'(n), 64'(W + 1));
    check({name, ".busy_cycles"}, 64'(busy_cnt), 64'(W));
    check({name, ".busy_at_done"}, 64'(bus.busy), 64'd0);
    check_outs(name, res, hi, z, 1'b0, 1'b0);
    @(posedge clk); #1;
    check({name, ".done_single"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int seen;
    bus.start = 1'b0; bus.op = 4'b0000; bus.a = 32'd0; bus.b = 32'd0;

    vecs[0]  = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{4'b0100, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'b0010, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'b0011, 32'h00001234, 32'h00001234, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'b0011, 32'h00001234, 32'h00001235, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{4'b0101, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4'b0110, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'b0110, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{4'b1000, 32'h00000001, 32'h00000004, 32'h00000010, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'b1000, 32'hA5A5A5A5, 32'h00000020, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{4'b1010, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{4'b1001, 32'h80000000, 32'h0000001F, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{4'b1010, 32'h40000000, 32'h00000001, 32'h20000000, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{4'b0100, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{4'b1100, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h5, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{4'b1101, 32'h00000000, 32'h00000000, 32'h00000000, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{4'b0111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset.busy_done", 64'({bus.busy, bus.done}), 64'd0);
    check_outs("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d.done", i), 64'(bus.done), 64'd1);
      check_outs($sformatf("vec%0d", i), vecs[i].res, vecs[i].hi, vecs[i].z, vecs[i].ovf, vecs[i].dbz);
      @(posedge clk); #1;
      check($sformatf("vec%0d.done_single", i), 64'(bus.done), 64'd0);
    end

    // Back-to-back: a start in the done cycle is accepted.
    issue(4'b0000, 32'd10, 32'd20);
    check("b2b.first", 64'(bus.result), 64'd30);
    bus.start = 1'b1; bus.op = 4'b0001; bus.a = 32'hFF; bus.b = 32'h0F;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b.done", 64'(bus.done), 64'd1);
    check("b2b.second", 64'(bus.result), 64'h0F);

    run_multi("mulu_ff_2", 4'b1011, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'h1, 1'b0, 1'b1);
    run_multi("divu_100_7", 4'b1100, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    run_multi("mulu_max", 4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_multi("mulu_zero", 4'b1011, 32'd0, 32'd5, 32'd0, 32'd0, 1'b1, 1'b0);
    run_multi("divu_3_10", 4'b1100, 32'd3, 32'd10, 32'd0, 32'd3, 1'b1, 1'b0);
    run_multi("divu_max_1", 4'b1100, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0);

    // Reset in cycle 10 of a multiply aborts it with no done.
    issue(4'b1011, 32'd3, 32'd5);
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("abort.busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.busy_done", 64'({bus.busy, bus.done}), 64'd0);
    check_outs("abort", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen++;
    end
    check("abort.no_done", 64'(seen), 64'd0);
    issue(4'b0000, 32'd3, 32'd4);
    check("after_abort.done", 64'(bus.done), 64'd1);
    check_outs("after_abort", 32'd7, 32'd0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Parameters
REQ-001 SHALL provide WIDTH, default 32, datapath width; legal values are powers of 2 from 8 to 64.
REQ-002 SHALL derive SHW = log2(WIDTH), default 5, the shift-amount width.

Interface
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request; sampled only when busy=0.
REQ-006 op  in  4  opcode, captured with start.
REQ-007 a, b  in  WIDTH each  operands, captured with start.
REQ-008 busy  out  1  iterative operation in progress.
REQ-009 done  out  1  one-cycle pulse: result fields valid and updated.
REQ-010 result  out  WIDTH  low result word, or quotient for DIVU.
REQ-011 result_hi  out  WIDTH  high product word (MULU) or remainder (DIVU); 0 for other ops.
REQ-012 zero  out  1  result==0.
REQ-013 overflow  out  1  signed overflow, ADD/SUB only; 0 otherwise.
REQ-014 div_by_zero  out  1  DIVU with b==0.

Function
REQ-015 Opcodes SHALL be: 0000 ADD, 0001 AND, 0010 OR, 0011 EQ (result=1 if a==b else 0), 0100 SUB, 0101 XOR, 0110 NOR, 0111 SLT (signed, result 1/0), 1000 SLL, 1001 SRL, 1010 SRA (shift a by b[SHW-1:0]), 1011 MULU, 1100 DIVU; 1101-1111 give result=0, all flags 0, with done still pulsing.
REQ-016 FSM SHALL have states IDLE, MUL, DIV; reset and default state IDLE.
REQ-017 IDLE + start + op not MULU/DIVU: outputs registered at the sampling edge; done=1 in the following cycle (latency 1); stay IDLE.
REQ-018 IDLE + start + MULU: go to MUL, busy=1, and run an unsigned shift-add using an internal counter for WIDTH iterations (one per edge). The final edge writes the 2*WIDTH product to {result_hi,result}, clears busy, returns to IDLE, and raises done in the next cycle (latency WIDTH+1).
REQ-019 IDLE + start + DIVU, b!=0: go to DIV and run an unsigned restoring divide with the same WIDTH-iteration timing as MUL. Quotient goes to result, remainder to result_hi.
REQ-020 DIVU with b==0: no iteration; result = all ones, result_hi = a, div_by_zero=1, latency 1.
REQ-021 start while busy=1 SHALL be ignored: no capture and no effect on the operation in progress.
REQ-022 Outputs SHALL hold their last values between done pulses, and during MUL/DIV.
REQ-023 zero, overflow and div_by_zero SHALL be updated on the same edge as result.
REQ-024 ADD/SUB SHALL wrap modulo 2^WIDTH. overflow = (sign a == sign b' ) && (sign result != sign a), where b' = b for ADD and -b for SUB.
REQ-025 done SHALL never be high for two consecutive cycles from a single start. start in the cycle in which done is high SHALL be accepted.
REQ-026 Shift by 0 SHALL return a unchanged. SRA SHALL replicate a[WIDTH-1].

Reset
REQ-027 rst=1 at any edge, including mid-MUL or mid-DIV, SHALL force IDLE and clear the internal counter and all outputs to 0: busy, done, result, result_hi, zero, overflow, div_by_zero.
REQ-028 No done pulse SHALL follow an aborted operation; the first start after rst deasserts SHALL be accepted normally.

Verification (WIDTH=32)
REQ-029 ADD a=0x7FFFFFFF, b=1 -> next cycle: done=1, result=0x80000000, overflow=1, zero=0.
REQ-030 SUB a=5, b=5, then SLT a=0xFFFFFFFF, b=1 -> result=0 with zero=1, then result=1.
REQ-031 MULU a=0xFFFFFFFF, b=2 -> busy for 32 cycles; done 33 cycles after start; result_hi=0x00000001, result=0xFFFFFFFE; a second start during busy is ignored.
REQ-032 DIVU a=100, b=7 -> done at cycle 33, result=14, result_hi=2. DIVU a=5, b=0 -> latency 1, result=0xFFFFFFFF, result_hi=5, div_by_zero=1.
REQ-033 rst pulsed at cycle 10 of a MULU -> next cycle busy=0 and all outputs 0, with no done; then ADD 3+4 -> result=7.
REQ-034 SRA a=0x80000000, b=31 -> 0xFFFFFFFF. SRL with the same operands -> 0x00000001. Opcode 1111 -> done=1, result=0.
